// File: rtl/pp_hazard_if.sv
// Hazard-unit bundle: pipeline-side inputs and hold/flush/bubble controls for pp_hazard.
// The master modport is the pipeline side, the slave modport is the hazard unit.
interface pp_hazard_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      instr_id;
  logic [4:0]       rt_ex;
  logic             mem_rd_en_ex;
  logic             branch;
  logic             jump_id;
  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             clear_ctrl;
  logic             ex_flush;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output instr_id, rt_ex, mem_rd_en_ex, branch, jump_id,
    input  pc_hold, ifid_hold, ifid_flush, clear_ctrl, ex_flush, busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  instr_id, rt_ex, mem_rd_en_ex, branch, jump_id,
    output pc_hold, ifid_hold, ifid_flush, clear_ctrl, ex_flush, busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pp_hazard.sv
// Load-use stall / branch and jump squash control for the 5-stage pipeline.
// Optional saturating statistics counters are built when PP_HAZARD_STATS_EN is defined.
module pp_hazard #(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input logic      clk,
  input logic      rstb,
  pp_hazard_if.slave hz
);
  localparam logic StRun   = 1'b0;
  localparam logic StStall = 1'b1;
  localparam logic [2:0] StallInit = 3'(STALL_CYCLES - 1);

  logic       state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic [5:0] op;
  logic [4:0] rs, rt;
  logic       uses_rs, uses_rt, hit;
  logic       stall_hold;
  logic       pc_hold, ifid_hold, ifid_flush, clear_ctrl, ex_flush;

  assign op = hz.instr_id[31:26];
  assign rs = hz.instr_id[25:21];
  assign rt = hz.instr_id[20:16];

  // j/jal read no register; only R-type, beq, bne and sw read rt.
  assign uses_rs = !(op == 6'b000010 || op == 6'b000011);
  assign uses_rt = (op == 6'b000000) || (op == 6'b000100) || (op == 6'b000101) ||
                   (op == 6'b101011);
  assign hit = hz.mem_rd_en_ex && (hz.rt_ex != 5'd0) &&
               ((uses_rs && (rs == hz.rt_ex)) || (uses_rt && (rt == hz.rt_ex)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    clear_ctrl = 1'b0;
    ex_flush   = 1'b0;
    stall_hold = 1'b0;
    if (hz.branch) begin
      ifid_flush = 1'b1;
      clear_ctrl = 1'b1;
      ex_flush   = 1'b1;
      state_d    = StRun;
      cnt_d      = 3'd0;
    end else if (state_q == StStall) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      clear_ctrl = 1'b1;
      stall_hold = 1'b1;
      cnt_d      = cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        state_d = StRun;
      end
    end else if (hit) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      clear_ctrl = 1'b1;
      stall_hold = 1'b1;
      if (STALL_CYCLES > 1) begin
        state_d = StStall;
        cnt_d   = StallInit;
      end
    end else if (hz.jump_id) begin
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q <= StRun;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low while reset is held, not just after the first edge.
  assign hz.pc_hold    = pc_hold    && !rstb;
  assign hz.ifid_hold  = ifid_hold  && !rstb;
  assign hz.ifid_flush = ifid_flush && !rstb;
  assign hz.clear_ctrl = clear_ctrl && !rstb;
  assign hz.ex_flush   = ex_flush   && !rstb;
  assign hz.busy       = (state_q == StStall) && !rstb;

`ifdef PP_HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_hold && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (hz.branch && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  logic unused_stall_hold;
  assign unused_stall_hold = stall_hold;
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pp_hazard.sv
// Scoreboard bench for pp_hazard: driver pushes model expectations, monitor pops and compares.
module tb_pp_hazard;
  localparam int unsigned STALL_CYCLES = 3;
  localparam int unsigned CNT_W        = 4;
  localparam int          CNT_MAX      = (1 << CNT_W) - 1;

  logic clk;
  logic rstb;

  pp_hazard_if #(.CNT_W(CNT_W)) hz ();

  pp_hazard #(
    .STALL_CYCLES(STALL_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rstb(rstb),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [5:0] ctl;  // {pc_hold, ifid_hold, ifid_flush, clear_ctrl, ex_flush, busy}
    int         sc;
    int         fc;
  } exp_t;

  exp_t exp_q[$];
  int   tests;
  int   fails;
  int   cyc;

  // Reference model: number of hold cycles still owed, plus event counts.
  int   remaining;
  int   m_stall;
  int   m_flush;

  function automatic bit ref_hit(input logic [31:0] ins, input logic [4:0] rte, input logic ld);
    int op, rs, rt;
    bit urs, urt;
    op  = int'(ins[31:26]);
    rs  = int'(ins[25:21]);
    rt  = int'(ins[20:16]);
    urs = !(op == 2 || op == 3);
    urt = (op == 0) || (op == 4) || (op == 5) || (op == 43);
    return ld && (rte != 0) && ((urs && rs == int'(rte)) || (urt && rt == int'(rte)));
  endfunction

  task automatic drive(input logic rst, input logic [31:0] ins, input logic [4:0] rte,
                       input logic ld, input logic br, input logic jmp);
    exp_t e;
    bit   h;
    @(negedge clk);
    rstb            = rst;
    hz.instr_id     = ins;
    hz.rt_ex        = rte;
    hz.mem_rd_en_ex = ld;
    hz.branch       = br;
    hz.jump_id      = jmp;
    e.idx = cyc;
    cyc++;
    h = ref_hit(ins, rte, ld);
    if (rst) begin
      e.ctl = 6'b0;
      e.sc  = 0;
      e.fc  = 0;
      exp_q.push_back(e);
      remaining = 0;
      m_stall   = 0;
      m_flush   = 0;
    end else begin
      e.sc  = m_stall;
      e.fc  = m_flush;
      e.ctl = 6'b0;
      e.ctl[0] = (remaining > 0);
      if (br) begin
        e.ctl[3:1] = 3'b111;
        remaining  = 0;
        if (m_flush < CNT_MAX) m_flush++;
      end else if (remaining > 0) begin
        e.ctl[5:4] = 2'b11;
        e.ctl[2]   = 1'b1;
        remaining--;
        if (m_stall < CNT_MAX) m_stall++;
      end else if (h) begin
        e.ctl[5:4] = 2'b11;
        e.ctl[2]   = 1'b1;
        remaining  = int'(STALL_CYCLES) - 1;
        if (m_stall < CNT_MAX) m_stall++;
      end else if (jmp) begin
        e.ctl[3] = 1'b1;
      end
      exp_q.push_back(e);
    end
  endtask

  // Monitor: the hazard outputs are valid every cycle, sampled mid-low-phase.
  initial begin
    exp_t e;
    logic [5:0] act;
    int esc, efc;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {hz.pc_hold, hz.ifid_hold, hz.ifid_flush, hz.clear_ctrl, hz.ex_flush, hz.busy};
`ifdef PP_HAZARD_STATS_EN
        esc = e.sc;
        efc = e.fc;
`else
        esc = 0;
        efc = 0;
`endif
        tests++;
        if (act !== e.ctl) begin
          fails++;
          $display("FAIL ctl cyc=%0d got=%b want=%b", e.idx, act, e.ctl);
        end
        tests++;
        if (hz.stall_cnt !== CNT_W'(esc)) begin
          fails++;
          $display("FAIL stall_cnt cyc=%0d got=%0d want=%0d", e.idx, hz.stall_cnt, esc);
        end
        tests++;
        if (hz.flush_cnt !== CNT_W'(efc)) begin
          fails++;
          $display("FAIL flush_cnt cyc=%0d got=%0d want=%0d", e.idx, hz.flush_cnt, efc);
        end
      end
    end
  end

  logic [31:0] add_651, addi_674, lw_op, rnd_ins;
  logic [5:0]  ops [8];

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    remaining = 0;
    m_stall   = 0;
    m_flush   = 0;
    rstb            = 1'b1;
    hz.instr_id     = '0;
    hz.rt_ex        = '0;
    hz.mem_rd_en_ex = 1'b0;
    hz.branch       = 1'b0;
    hz.jump_id      = 1'b0;
    add_651  = {6'd0, 5'd5, 5'd1, 5'd6, 5'd0, 6'h20};
    addi_674 = {6'b001000, 5'd7, 5'd6, 16'd4};
    lw_op    = {6'b100011, 5'd2, 5'd3, 16'd0};
    ops = '{6'b000000, 6'b000100, 6'b000101, 6'b101011,
            6'b100011, 6'b001000, 6'b000010, 6'b000011};

    drive(1, add_651, 5'd5, 1, 0, 0);  // reset dominates a live hazard
    drive(1, '0, '0, 0, 0, 0);
    drive(0, '0, '0, 0, 0, 0);
    // Load-use: 3 hold cycles, busy on the last two.
    drive(0, add_651, 5'd5, 1, 0, 0);
    drive(0, add_651, 5'd5, 1, 0, 0);
    drive(0, add_651, 5'd5, 1, 0, 1);
    drive(0, add_651, 5'd9, 0, 0, 0);
    // No hazard: rt_ex=0, addi vs $5, addi rt ignored, non-load.
    drive(0, add_651, 5'd0, 1, 0, 0);
    drive(0, addi_674, 5'd5, 1, 0, 0);
    drive(0, addi_674, 5'd6, 1, 0, 0);
    drive(0, add_651, 5'd5, 0, 0, 0);
    // Branch beats a hit; no stall entered.
    drive(0, add_651, 5'd5, 1, 1, 0);
    drive(0, addi_674, 5'd1, 0, 0, 1);
    // Branch aborts a stall in progress.
    drive(0, add_651, 5'd1, 1, 0, 0);
    drive(0, add_651, 5'd1, 1, 1, 0);
    drive(0, lw_op, 5'd0, 0, 0, 0);
    // Reset mid-stall.
    drive(0, add_651, 5'd5, 1, 0, 0);
    drive(0, add_651, 5'd5, 1, 0, 0);
    drive(1, add_651, 5'd5, 1, 0, 0);
    drive(0, lw_op, 5'd0, 0, 0, 1);
    // Saturate both counters.
    for (int i = 0; i < 20; i++) drive(0, add_651, 5'd5, 1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, add_651, 5'd1, 1, 0, 0);
      drive(0, '0, '0, 0, 0, 0);
      drive(0, '0, '0, 0, 0, 0);
    end
    drive(0, '0, '0, 0, 0, 0);
    drive(1, '0, '0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      rnd_ins = $urandom;
      rnd_ins[31:26] = ops[$urandom_range(0, 7)];
      rnd_ins[25:21] = 5'($urandom_range(0, 3));
      rnd_ins[20:16] = 5'($urandom_range(0, 3));
      drive(($urandom_range(0, 99) == 0), rnd_ins, 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 4) == 0));
    end
    drive(0, '0, '0, 0, 0, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #4;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
